// File: rtl/if_id_skid_pkg.sv
// Shared types for the IF/ID skid buffer: FSM state, default NOP and payload layout.
// Latency/backpressure: none, declarations only.
package if_id_pkg;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   localparam int unsigned INSTR_W_DEF = 32;
   localparam int unsigned PC_W_DEF    = 64;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } if_id_state_e;

   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instruction;
      logic [PC_W_DEF-1:0]    pc;
   } if_id_payload_t;

endpackage

// File: rtl/if_id_skid_if.sv
// Fetch/decode handshake bundle for the IF/ID skid buffer.
// master drives the fetch beat, flush and out_ready; slave is the buffer.
interface if_id_skid_if #(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned PC_W    = 64
);
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] instruction_in;
   logic [PC_W-1:0]    pc;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] instruction_out;
   logic [PC_W-1:0]    out_pc;

   modport master (
      output in_valid, instruction_in, pc, flush, out_ready,
      input  in_ready, out_valid, instruction_out, out_pc
   );

   modport slave (
      input  in_valid, instruction_in, pc, flush, out_ready,
      output in_ready, out_valid, instruction_out, out_pc
   );
endinterface

// File: rtl/if_id_skid_sat_counter.sv
// Saturating event counter with synchronous clear; updates one cycle after inc.
// No backpressure: sticks at all-ones until cleared.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID two-entry skid buffer (optional perf counters: IF_ID_PERF_CNT_EN); 1-cycle latency, 1 beat/cycle.
// Backpressure: in_ready comes from state only, so one extra beat is absorbed into skid when decode stalls.
module if_id_skid
   import if_id_pkg::*;
#(
   parameter int unsigned        INSTR_W   = 32,
   parameter int unsigned        PC_W      = 64,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(RV_NOP)
`ifdef IF_ID_PERF_CNT_EN
   ,
   parameter int unsigned        CNT_W     = 32
`endif
) (
   input  logic             clk,
   input  logic             rst,
   if_id_skid_if.slave      bus
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   typedef struct packed {
      logic [INSTR_W-1:0] instruction;
      logic [PC_W-1:0]    pc;
   } payload_t;

   if_id_state_e state_q;
   if_id_state_e state_d;
   payload_t     main_q;
   payload_t     skid_q;
   payload_t     in_beat;

   logic accept;
   logic drain;
   logic load_main;
   logic load_skid;
   logic skid_to_main;

   assign in_beat = '{instruction: bus.instruction_in, pc: bus.pc};
   assign accept  = bus.in_valid & bus.in_ready;
   assign drain   = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) state_d = ONE;
            end
            ONE: begin
               if (accept && !drain)      state_d = TWO;
               else if (!accept && drain) state_d = EMPTY;
            end
            TWO: begin
               if (drain) state_d = ONE;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // rst is folded into in_ready so fetch sees "ready" while held in reset;
   // the beats it offers are still discarded by the gating below.
   always_comb begin
      bus.in_ready        = rst | (state_q != TWO);
      bus.out_valid       = (state_q != EMPTY);
      bus.instruction_out = bus.out_valid ? main_q.instruction : NOP_INSTR;
      bus.out_pc          = bus.out_valid ? main_q.pc : '0;
   end

   always_comb begin
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (!rst && !bus.flush) begin
         load_main    = accept & ((state_q == EMPTY) | ((state_q == ONE) & drain));
         load_skid    = accept & (state_q == ONE) & ~drain;
         skid_to_main = drain & (state_q == TWO);
      end
   end

   // Payload registers need no reset: they are only visible when out_valid is set.
   always_ff @(posedge clk) begin
      if (load_main) begin
         main_q <= in_beat;
      end else if (skid_to_main) begin
         main_q <= skid_q;
      end
      if (load_skid) begin
         skid_q <= in_beat;
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (bus.out_valid & ~bus.out_ready),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .clr (rst),
      .inc (bus.flush & bus.out_valid),
      .cnt (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Randomised + directed bench for if_id_skid against a queue-based reference model.
module tb_if_id_skid;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_id_skid_if #(.INSTR_W(32), .PC_W(64)) bus ();

`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [1:0]  stall_cnt2;
   logic [1:0]  flush_cnt2;

   if_id_skid_if #(.INSTR_W(32), .PC_W(64)) bus2 ();
   assign bus2.in_valid       = bus.in_valid;
   assign bus2.instruction_in = bus.instruction_in;
   assign bus2.pc             = bus.pc;
   assign bus2.flush          = bus.flush;
   assign bus2.out_ready      = bus.out_ready;

   if_id_skid #(.INSTR_W(32), .PC_W(64), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );
   if_id_skid #(.INSTR_W(32), .PC_W(64), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
   );
`else
   if_id_skid #(.INSTR_W(32), .PC_W(64)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
`endif

   typedef struct {
      logic [31:0] ins;
      logic [63:0] pc;
   } beat_t;

   beat_t   mq[$];
   longint  stall_m, flush_m, stall2_m, flush2_m;
   int      n_err = 0;
   int      n_chk = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check at the falling edge, advance the model, cross the rising edge.
   task automatic cycle(input bit r, input bit iv, input logic [31:0] ins, input logic [63:0] p,
                        input bit fl, input bit ordy, output bit acc);
      bit drn;
      rst                = r;
      bus.in_valid       = iv;
      bus.instruction_in = ins;
      bus.pc             = p;
      bus.flush          = fl;
      bus.out_ready      = ordy;
      @(negedge clk);
      chk("in_ready", {63'd0, bus.in_ready}, r ? 64'd1 : {63'd0, mq.size() < 2});
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, mq.size() > 0});
      chk("instruction_out", {32'd0, bus.instruction_out}, {32'd0, (mq.size() > 0) ? mq[0].ins : 32'h0000_0013});
      chk("out_pc", bus.out_pc, (mq.size() > 0) ? mq[0].pc : 64'd0);
`ifdef IF_ID_PERF_CNT_EN
      chk("stall_cnt", {32'd0, stall_cnt}, stall_m[63:0]);
      chk("flush_cnt", {32'd0, flush_cnt}, flush_m[63:0]);
      chk("stall_cnt_w2", {62'd0, stall_cnt2}, stall2_m[63:0]);
      chk("flush_cnt_w2", {62'd0, flush_cnt2}, flush2_m[63:0]);
`endif
      acc = !r && !fl && iv && (mq.size() < 2);
      drn = (mq.size() > 0) && ordy;
      if (r) begin
         mq.delete();
         stall_m = 0; flush_m = 0; stall2_m = 0; flush2_m = 0;
      end else begin
         if ((mq.size() > 0) && !ordy) begin
            if (stall_m < 64'hFFFF_FFFF) stall_m++;
            if (stall2_m < 3) stall2_m++;
         end
         if (fl && (mq.size() > 0)) begin
            if (flush_m < 64'hFFFF_FFFF) flush_m++;
            if (flush2_m < 3) flush2_m++;
         end
         if (fl) begin
            mq.delete();
         end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back('{ins: ins, pc: p});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit ordy);
      bit a;
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, ordy, a);
   endtask

   initial begin
      bit          a, r, iv, fl, ordy, pend;
      logic [31:0] pi;
      logic [63:0] pp;

      stall_m = 0; flush_m = 0; stall2_m = 0; flush2_m = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.instruction_in = '0; bus.pc = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 64'h40, 1'b0, 1'b1, a);
      cycle(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b1, a);

      // single beat, 1-cycle latency
      cycle(1'b0, 1'b1, 32'h1122_3344, 64'h1234_5678_90AB_CDEF, 1'b0, 1'b1, a);
      idle(2, 1'b1);

      // 8-beat stream at full rate
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 64'(i * 4), 1'b0, 1'b1, a);
      idle(2, 1'b1);

      // backpressure: A, B absorbed, C held at source
      cycle(1'b0, 1'b1, 32'h0000_00AA, 64'h100, 1'b0, 1'b0, a);
      cycle(1'b0, 1'b1, 32'h0000_00BB, 64'h104, 1'b0, 1'b0, a);
      cycle(1'b0, 1'b1, 32'h0000_00CC, 64'h108, 1'b0, 1'b0, a);
      cycle(1'b0, 1'b1, 32'h0000_00CC, 64'h108, 1'b0, 1'b0, a);
      a = 1'b0;
      for (int k = 0; k < 4 && !a; k++)
         cycle(1'b0, 1'b1, 32'h0000_00CC, 64'h108, 1'b0, 1'b1, a);
      idle(3, 1'b1);

      // flush in TWO with a new beat D arriving
      cycle(1'b0, 1'b1, 32'h0000_0A0A, 64'h200, 1'b0, 1'b0, a);
      cycle(1'b0, 1'b1, 32'h0000_0B0B, 64'h204, 1'b0, 1'b0, a);
      cycle(1'b0, 1'b1, 32'h0000_0D0D, 64'h208, 1'b1, 1'b0, a);
      idle(2, 1'b1);

      // reset while holding one beat
      cycle(1'b0, 1'b1, 32'h0000_0E0E, 64'h300, 1'b0, 1'b0, a);
      cycle(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, a);
      idle(2, 1'b1);

      // 3 stall cycles then a flush with a valid beat held
      cycle(1'b0, 1'b1, 32'h0000_0F0F, 64'h400, 1'b0, 1'b1, a);
      idle(3, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, a);
      idle(4, 1'b0);
      cycle(1'b0, 1'b1, 32'h0000_1111, 64'h500, 1'b0, 1'b0, a);
      idle(6, 1'b0);
      idle(2, 1'b1);

      // random traffic; an unaccepted beat is re-offered unchanged
      pend = 1'b0;
      pi = '0;
      pp = '0;
      for (int n = 0; n < 600; n++) begin
         r    = ($urandom_range(63) == 0);
         fl   = ($urandom_range(15) == 0);
         ordy = ($urandom_range(3) != 0);
         iv   = ($urandom_range(3) != 0);
         if (!pend) begin
            pi   = $urandom;
            pp   = {$urandom, $urandom};
            pend = 1'b1;
         end
         cycle(r, iv, pi, pp, fl, ordy, a);
         if (a) pend = 1'b0;
      end
      idle(3, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
